// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM, with per-port lock/ownership.
// Define MEM_ARBITER_RR_EN for round-robin contention in IDLE; otherwise A has fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  // state | meaning
  // IDLE  | no owner, both requesters arbitrate
  // OWN_A | A holds the RAM, B is ignored while a_req stays high
  // OWN_B | B holds the RAM, A is ignored while b_req stays high
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   a_rv_q, b_rv_q;
  logic   arb_open;
  logic   prefer_b;
  logic   mux_b;

`ifdef MEM_ARBITER_RR_EN
  logic ptr_q, ptr_d;

  assign prefer_b = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (arb_open && a_gnt) ptr_d = 1'b1;
    if (arb_open && b_gnt) ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  assign prefer_b = 1'b0;
`endif

  // An owner that drops its request releases the RAM in that same cycle,
  // so the other side arbitrates as if from IDLE without a dead cycle.
  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    arb_open = 1'b0;
    state_d  = IDLE;
    sel_d    = sel_q;
    if (!rst) begin
      unique case (state_q)
        OWN_A: begin
          if (a_req) a_gnt = 1'b1;
          else       arb_open = 1'b1;
        end
        OWN_B: begin
          if (b_req) b_gnt = 1'b1;
          else       arb_open = 1'b1;
        end
        default: arb_open = 1'b1;
      endcase
      if (arb_open) begin
        if (a_req && b_req) begin
          if (prefer_b) b_gnt = 1'b1;
          else          a_gnt = 1'b1;
        end else if (a_req) begin
          a_gnt = 1'b1;
        end else if (b_req) begin
          b_gnt = 1'b1;
        end
      end
      if (a_gnt) begin
        sel_d   = 1'b0;
        state_d = a_lock ? OWN_A : IDLE;
      end else if (b_gnt) begin
        sel_d   = 1'b1;
        state_d = b_lock ? OWN_B : IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      a_rv_q  <= a_gnt & ~a_we;
      b_rv_q  <= b_gnt & ~b_we;
    end
  end

  assign mux_b       = a_gnt ? 1'b0 : (b_gnt ? 1'b1 : sel_q);
  assign mem_addr    = mux_b ? b_addr : a_addr;
  assign mem_wr_data = mux_b ? b_wdata : a_wdata;
  assign mem_wr_en   = (a_gnt & a_we) | (b_gnt & b_we);

  // Gate with rst so a response for a read issued just before reset is dropped.
  assign a_rvalid = a_rv_q & ~rst;
  assign b_rvalid = b_rv_q & ~rst;
  assign a_rdata  = mem_rd_data;
  assign b_rdata  = mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a behavioural synchronous RAM.
// Contention expectations follow MEM_ARBITER_RR_EN when it is defined.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wr_en;
  logic [7:0] a_rdata, b_rdata, mem_addr, mem_wr_data;
  logic [7:0] mem_rd_data;
  logic       tb_init;
  logic [7:0] ram [256];

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // RAM preloaded with ram[i] = i so unwritten locations read back predictably
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
      mem_rd_data <= 8'h00;
    end else begin
      if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
      mem_rd_data <= ram[mem_addr];
    end
  end

  typedef struct packed {
    logic       rst;
    logic       a_req;
    logic       a_we;
    logic       a_lock;
    logic [7:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_req;
    logic       b_we;
    logic       b_lock;
    logic [7:0] b_addr;
    logic [7:0] b_wdata;
    logic       e_agnt;
    logic       e_bgnt;
    logic       e_arv;
    logic       e_brv;
    logic       e_wr;
    logic       chk_addr;
    logic [7:0] e_addr;
    logic [7:0] e_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec %0d %s: got %h want %h", cur, name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst;
    a_req = v.a_req; a_we = v.a_we; a_lock = v.a_lock; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_lock = v.b_lock; b_addr = v.b_addr; b_wdata = v.b_wdata;
    @(negedge clk);
    chk("a_gnt", {7'd0, a_gnt}, {7'd0, v.e_agnt});
    chk("b_gnt", {7'd0, b_gnt}, {7'd0, v.e_bgnt});
    chk("a_rvalid", {7'd0, a_rvalid}, {7'd0, v.e_arv});
    chk("b_rvalid", {7'd0, b_rvalid}, {7'd0, v.e_brv});
    chk("mem_wr_en", {7'd0, mem_wr_en}, {7'd0, v.e_wr});
    if (v.chk_addr) chk("mem_addr", mem_addr, v.e_addr);
    if (v.e_arv) chk("a_rdata", a_rdata, v.e_rdata);
    if (v.e_brv) chk("b_rdata", b_rdata, v.e_rdata);
    cur++;
  endtask

  vec_t vecs [30];
  vec_t v;
  logic [3:0] win_a;
  logic prev_a;

  initial begin
    // rst  aq we lk aaddr  awdata bq we lk baddr  bwdata  ag bg arv brv wr ca eaddr  erdata
    vecs[0]  = '{1, 1,1,0, 8'h10,8'h5A, 0,0,0, 8'h10,8'h00, 0,0,0,0,0, 0,8'h00,8'h00};
    vecs[1]  = '{0, 1,1,0, 8'h10,8'h5A, 0,0,0, 8'h10,8'h00, 1,0,0,0,1, 1,8'h10,8'h00};
    vecs[2]  = '{0, 0,0,0, 8'h10,8'h5A, 1,0,0, 8'h10,8'h00, 0,1,0,0,0, 1,8'h10,8'h00};
    vecs[3]  = '{0, 0,0,0, 8'h10,8'h5A, 0,0,0, 8'h10,8'h00, 0,0,0,1,0, 1,8'h10,8'h5A};
    vecs[4]  = '{0, 1,1,0, 8'h01,8'h33, 0,0,0, 8'h10,8'h00, 1,0,0,0,1, 1,8'h01,8'h00};
    vecs[5]  = '{0, 0,0,0, 8'h01,8'h33, 0,0,0, 8'h10,8'h00, 0,0,0,0,0, 1,8'h01,8'h00};
    vecs[6]  = '{0, 0,0,0, 8'h01,8'h33, 0,0,0, 8'h10,8'h00, 0,0,0,0,0, 1,8'h01,8'h00};
    vecs[7]  = '{0, 1,0,0, 8'h01,8'h00, 0,0,0, 8'h10,8'h00, 1,0,0,0,0, 1,8'h01,8'h00};
    vecs[8]  = '{0, 0,0,0, 8'h01,8'h00, 0,0,0, 8'h10,8'h00, 0,0,1,0,0, 1,8'h01,8'h33};
    vecs[9]  = '{0, 0,0,0, 8'h01,8'h00, 1,1,1, 8'h20,8'h00, 0,1,0,0,1, 1,8'h20,8'h00};
    vecs[10] = '{0, 1,0,0, 8'h20,8'h00, 1,0,1, 8'h20,8'h00, 0,1,0,0,0, 1,8'h20,8'h00};
    vecs[11] = '{0, 1,0,0, 8'h20,8'h00, 1,1,0, 8'h20,8'hC3, 0,1,0,1,1, 1,8'h20,8'h00};
    vecs[12] = '{0, 1,0,0, 8'h20,8'h00, 0,0,0, 8'h20,8'h00, 1,0,0,0,0, 1,8'h20,8'h00};
    vecs[13] = '{0, 0,0,0, 8'h20,8'h00, 0,0,0, 8'h20,8'h00, 0,0,1,0,0, 1,8'h20,8'hC3};
    vecs[14] = '{0, 0,0,0, 8'h20,8'h00, 1,0,1, 8'h30,8'h00, 0,1,0,0,0, 1,8'h30,8'h00};
    vecs[15] = '{0, 1,0,0, 8'h40,8'h00, 1,0,1, 8'h31,8'h00, 0,1,0,1,0, 1,8'h31,8'h30};
    vecs[16] = '{0, 1,0,0, 8'h40,8'h00, 0,0,0, 8'h31,8'h00, 1,0,0,1,0, 1,8'h40,8'h31};
    vecs[17] = '{0, 0,0,0, 8'h40,8'h00, 0,0,0, 8'h31,8'h00, 0,0,1,0,0, 1,8'h40,8'h40};
    vecs[18] = '{0, 1,0,0, 8'h02,8'h00, 0,0,0, 8'h31,8'h00, 1,0,0,0,0, 1,8'h02,8'h00};
    vecs[19] = '{1, 0,0,0, 8'h02,8'h00, 0,0,0, 8'h31,8'h00, 0,0,0,0,0, 0,8'h00,8'h00};
    vecs[20] = '{0, 0,0,0, 8'h02,8'h00, 0,0,0, 8'h31,8'h00, 0,0,0,0,0, 1,8'h02,8'h00};
    vecs[21] = '{0, 1,0,1, 8'h05,8'h00, 0,0,0, 8'h31,8'h00, 1,0,0,0,0, 1,8'h05,8'h00};
    vecs[22] = '{1, 0,0,0, 8'h05,8'h00, 1,1,0, 8'h06,8'h77, 0,0,0,0,0, 0,8'h00,8'h00};
    vecs[23] = '{0, 0,0,0, 8'h05,8'h00, 1,0,0, 8'h06,8'h00, 0,1,0,0,0, 1,8'h06,8'h00};
    vecs[24] = '{0, 0,0,0, 8'h05,8'h00, 0,0,0, 8'h06,8'h00, 0,0,0,1,0, 1,8'h06,8'h06};
    vecs[25] = '{0, 1,0,1, 8'h07,8'h00, 0,0,0, 8'h06,8'h00, 1,0,0,0,0, 1,8'h07,8'h00};
    vecs[26] = '{0, 1,1,1, 8'h07,8'hAA, 1,0,0, 8'h08,8'h00, 1,0,1,0,1, 1,8'h07,8'h07};
    vecs[27] = '{0, 1,0,0, 8'h07,8'h00, 1,0,0, 8'h08,8'h00, 1,0,0,0,0, 1,8'h07,8'h00};
    vecs[28] = '{0, 0,0,0, 8'h07,8'h00, 1,0,0, 8'h08,8'h00, 0,1,1,0,0, 1,8'h08,8'hAA};
    vecs[29] = '{0, 0,0,0, 8'h07,8'h00, 0,0,0, 8'h08,8'h00, 0,0,0,1,0, 1,8'h08,8'h08};

    tb_init = 1'b1;
    rst = 1'b1;
    a_req = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
    @(posedge clk);
    #1 tb_init = 1'b0;

    for (int i = 0; i < 30; i++) apply(vecs[i]);

    // Contended back-to-back reads from a fresh reset: A at 0x07 (holds 0xAA), B at 0x08.
`ifdef MEM_ARBITER_RR_EN
    win_a = 4'b0101;
`else
    win_a = 4'b1111;
`endif
    v = '{1, 0,0,0, 8'h07,8'h00, 0,0,0, 8'h08,8'h00, 0,0,0,0,0, 0,8'h00,8'h00};
    apply(v);
    prev_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      v = '{0, 0,0,0, 8'h07,8'h00, 0,0,0, 8'h08,8'h00, 0,0,0,0,0, 1,8'h00,8'h00};
      v.a_req  = (k < 4);
      v.b_req  = (k < 4);
      v.e_agnt = (k < 4) && win_a[k % 4];
      v.e_bgnt = (k < 4) && !win_a[k % 4];
      v.e_arv  = (k > 0) && prev_a;
      v.e_brv  = (k > 0) && !prev_a;
      v.e_rdata = prev_a ? 8'hAA : 8'h08;
      if (k < 4) v.e_addr = win_a[k % 4] ? 8'h07 : 8'h08;
      else       v.e_addr = prev_a ? 8'h07 : 8'h08;
      apply(v);
      if (k < 4) prev_a = win_a[k % 4];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 8, memory address width.
REQ-002 Parameter: DATA_WIDTH, default 8, memory word width.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Ports: a_req/b_req  input  1  requester A/B access request, held until granted.
REQ-006 Ports: a_we/b_we  input  1  1 = write, 0 = read.
REQ-007 Ports: a_lock/b_lock  input  1  retain ownership after this access.
REQ-008 Ports: a_addr/b_addr  input  ADDR_WIDTH  access address.
REQ-009 Ports: a_wdata/b_wdata  input  DATA_WIDTH  write data.
REQ-010 Ports: a_gnt/b_gnt  output  1  access accepted this cycle, combinational.
REQ-011 Ports: a_rvalid/b_rvalid  output  1  read data valid, registered.
REQ-012 Ports: a_rdata/b_rdata  output  DATA_WIDTH  read data.
REQ-013 Ports: mem_wr_en  output  1; mem_addr  output  ADDR_WIDTH; mem_wr_data  output  DATA_WIDTH  drive of single-port RAM.
REQ-014 Port: mem_rd_data  input  DATA_WIDTH  RAM read data, valid one cycle after read address presented.

Function
REQ-015 Owner FSM states SHALL be IDLE, OWN_A, OWN_B.
REQ-016 IDLE with one request: grant that requester; with both: grant per REQ-031.
REQ-017 Granted access with lock=1 SHALL transition to OWN_x; lock=0 SHALL return/stay IDLE.
REQ-018 In OWN_x only requester x SHALL be granted; other requester's req ignored (no gnt).
REQ-019 OWN_x SHALL exit to IDLE on a granted access by x with lock=0, or on a cycle where x_req=0.
REQ-020 At most one gnt per cycle; gnt only when corresponding req=1.
REQ-021 Granted cycle: mem_addr/mem_wr_data/mem_wr_en SHALL be the granted port's addr/wdata/we, same cycle, combinational.
REQ-022 No grant: mem_wr_en=0; mem_addr/mem_wr_data hold last granted values (registered mux select).
REQ-023 Read granted at cycle N: x_rvalid=1 exactly in cycle N+1, x_rdata=mem_rd_data in that cycle.
REQ-024 Writes SHALL produce no rvalid.
REQ-025 Back-to-back reads (same or alternating ports) SHALL sustain one access per cycle; rvalid tagged to the port granted in the prior cycle.
REQ-026 x_rdata SHALL be driven from mem_rd_data continuously; meaningful only when x_rvalid=1.
REQ-027 A request with lock=1 arriving in IDLE SHALL be granted the same cycle (no extra acquire cycle).

Reset
REQ-028 rst=1 SHALL force: FSM=IDLE, a_rvalid=b_rvalid=0, priority pointer=A, mux select=A.
REQ-029 During rst=1: a_gnt=b_gnt=0, mem_wr_en=0; no RAM write SHALL occur.
REQ-030 Reset during OWN_x or with a read in flight: response SHALL be dropped (no rvalid in the cycle after reset deasserts); ownership lost.

Configuration
REQ-031 Macro MEM_ARBITER_RR_EN: defined -> IDLE contention resolved round-robin, pointer toggles to the non-granted port after each contended or uncontended grant in IDLE; undefined -> fixed priority, A always wins contention in IDLE.
REQ-032 Lock/ownership behaviour SHALL be identical with or without MEM_ARBITER_RR_EN.

Verification
REQ-033 A write addr 0x10 data 0x5A, then B read 0x10 -> b_gnt same cycles, b_rvalid=1 next cycle with b_rdata=0x5A, a_rvalid stays 0.
REQ-034 a_req=b_req=1 reads for 4 cycles, RR_EN defined -> grants A,B,A,B; rvalid follows one cycle later in same order; RR_EN undefined -> A,A,A,A, b_gnt=0.
REQ-035 B lock read 0x20 then unlock write 0x20 data 0xC3 while a_req=1 -> a_gnt=0 both cycles, a_gnt=1 third cycle, A read 0x20 returns 0xC3.
REQ-036 B in OWN_B drops b_req -> FSM IDLE, pending a_req granted the same cycle b_req is 0.
REQ-037 Assert rst in cycle after A read grant -> a_rvalid=0 during and after reset, mem_wr_en=0, FSM IDLE.
REQ-038 Idle cycles (no req) after write 0x33 to 0x01 -> mem_wr_en=0, mem_addr holds 0x01, no RAM corruption on readback.
